// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling default and the baud divider computation used by the transmitter too.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes; a push into a full FIFO is
// dropped and flagged on overflow unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign overflow  = push && full && !pop;
    // Head is forced to zero while empty so nothing stale leaks out after reset.
    assign dout      = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: input synchronizer, oversample tick generator and frame FSM
// feeding a small show-ahead FIFO, with sticky framing and overrun flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_channel,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output rx_state_t  dbg_state
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_chk
        $error("uart_receiver: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end

    logic [1:0]    r_sync;
    logic [TW-1:0] r_tcnt;
    rx_state_t     r_state;
    logic [3:0]    r_scnt;
    logic [2:0]    r_bcnt;
    logic [7:0]    r_shift;
    logic          r_busy;
    logic          r_frame_err;
    logic          r_overrun;

    logic w_rxs;
    logic w_tick;
    logic w_push;
    logic w_empty;
    logic w_overflow;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_tcnt == TW'(DIV - 1));
    // A byte is accepted on the stop-bit sample tick only if the stop bit is high.
    assign w_push = w_tick && (r_state == ST_STOP) && (r_scnt == 4'd15) && w_rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_channel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Clear first so a coinciding set event below takes priority.
            if (err_clr) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_overflow) begin
                r_overrun <= 1'b1;
            end
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rxs) begin
                            r_scnt  <= '0;
                            r_state <= ST_START;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == 4'd7) begin
                            if (!w_rxs) begin
                                r_scnt  <= '0;
                                r_bcnt  <= '0;
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == 4'd15) begin
                            r_shift <= {w_rxs, r_shift[7:1]};
                            r_bcnt  <= r_bcnt + 3'd1;
                            if (r_bcnt == 3'd7) begin
                                r_scnt  <= '0;
                                r_state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == 4'd15) begin
                            if (!w_rxs) begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .din      (r_shift),
        .pop      (rd_en),
        .dout     (rx_data),
        .empty    (w_empty),
        .full     (rx_full),
        .overflow (w_overflow)
    );

    assign rx_valid  = !w_empty;
    assign rx_busy   = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a queue-based model of the receive
// FIFO and sticky flags; the DUT runs at 64 clk per bit to keep frames short.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned BAUD    = 1_562_500;
    localparam int unsigned OS      = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int          DIV     = CLK_HZ / (BAUD * OS);
    localparam int          BIT_CLK = DIV * OS;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_channel;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    rx_state_t  dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_fe  = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_receiver #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_channel (rx_channel),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_full    (rx_full),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk1({tag, ".valid"}, rx_valid, exp_q.size() > 0);
        chk1({tag, ".full"}, rx_full, exp_q.size() == DEPTH);
        if (exp_q.size() > 0) chk8({tag, ".data"}, rx_data, exp_q[0]);
        chk1({tag, ".frame_err"}, frame_err, exp_fe);
        chk1({tag, ".overrun"}, overrun, exp_ovr);
        chk1({tag, ".busy"}, rx_busy, 1'b0);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_fe = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_channel = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_channel = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_channel = stop;
        repeat (BIT_CLK) @(negedge clk);
        rx_channel = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        model_frame(b, stop);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic glitch(input int width);
        @(negedge clk);
        rx_channel = 1'b0;
        repeat (width) @(negedge clk);
        rx_channel = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         k;

        rst        = 1'b1;
        rx_channel = 1'b1;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        repeat (5) @(negedge clk);
        chk1("reset.valid", rx_valid, 1'b0);
        chk1("reset.full", rx_full, 1'b0);
        chk8("reset.data", rx_data, 8'h00);
        chk1("reset.busy", rx_busy, 1'b0);
        chk1("reset.frame_err", frame_err, 1'b0);
        chk1("reset.overrun", overrun, 1'b0);
        chk8("reset.state", 8'(dbg_state), 8'(ST_IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single byte then pop
        send_frame(8'hA5, 1'b1);
        check_all("single");
        pop_one();
        check_all("single_pop");

        // glitch shorter than half a bit
        glitch(20);
        check_all("glitch");
        chk8("glitch.state", 8'(dbg_state), 8'(ST_IDLE));

        // framing error and clear
        send_frame(8'h3C, 1'b0);
        check_all("frame_err");
        clear_err();
        check_all("frame_err_clr");

        // overrun: five bytes, no reads
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        check_all("overrun");
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_all("overrun_pop");
        end
        clear_err();

        // push/pop collision on a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        check_all("coll_fill");
        b = 8'h55;
        @(negedge clk);
        rx_channel = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx_channel = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_channel = b[7];
        k = 0;
        while (dbg_state !== ST_STOP && k < BIT_CLK) begin
            @(negedge clk);
            k++;
        end
        chk1("coll.stop_reached", k < BIT_CLK, 1'b1);
        // stop sample lands 16 ticks after the STOP entry edge
        for (int j = 1; j <= OS * DIV; j++) begin
            @(negedge clk);
            if (j == BIT_CLK - k) rx_channel = 1'b1;
            if (j == OS * DIV - 1) rd_en = 1'b1;
            if (j == OS * DIV) rd_en = 1'b0;
        end
        rx_channel = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        check_all("collision");
        while (exp_q.size() > 0) begin
            pop_one();
            check_all("coll_drain");
        end

        // reset during bit 3 of 0xF0, with a byte already queued
        send_frame(8'h12, 1'b1);
        clear_err();
        b = 8'hF0;
        @(negedge clk);
        rx_channel = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_channel = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_channel = b[3];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst.valid", rx_valid, 1'b0);
        chk1("midrst.full", rx_full, 1'b0);
        chk8("midrst.data", rx_data, 8'h00);
        chk1("midrst.busy", rx_busy, 1'b0);
        chk1("midrst.frame_err", frame_err, 1'b0);
        chk1("midrst.overrun", overrun, 1'b0);
        rx_channel = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        check_all("post_rst_idle");
        send_frame(8'h81, 1'b1);
        check_all("post_rst_byte");
        pop_one();

        // randomized traffic against the model
        for (int n = 0; n < 14; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop);
            check_all("rand_frame");
            if ($urandom_range(0, 3) == 0) begin
                glitch($urandom_range(4, 24));
                check_all("rand_glitch");
            end
            for (int p = $urandom_range(0, 2); p > 0; p--) begin
                pop_one();
                check_all("rand_pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_err();
                check_all("rand_clr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
